// File: rtl/product_bcd_display_if.sv
// Interface bundle for product_bcd_display: the request side (start/sign/product)
// and the registered result side (busy/done/ovf/bcd/seg/seg_minus).
interface product_bcd_display_if #(
    parameter int DW_2       = 8,
    parameter int NUM_DIGITS = 3
);
    logic                      start;
    logic                      sign;
    logic [DW_2-1:0]           product;
    logic                      busy;
    logic                      done;
    logic                      ovf;
    logic [4*NUM_DIGITS-1:0]   bcd;
    logic [7*NUM_DIGITS-1:0]   seg;
    logic                      seg_minus;

    modport master (
        output start, sign, product,
        input  busy, done, ovf, bcd, seg, seg_minus
    );

    modport slave (
        input  start, sign, product,
        output busy, done, ovf, bcd, seg, seg_minus
    );
endinterface

// File: rtl/product_bcd_display.sv
// product_bcd_display
//  Captures {sign, product} on a start pulse, converts the magnitude to BCD with
//  a sequential shift-add-3 (double dabble) loop, and drives 7-segment patterns
//  plus a minus segment. Results are held in output registers until the next
//  completed conversion.
//  Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits above
//  digit 0 on the segment outputs; bcd is never blanked).
module product_bcd_display #(
    parameter int DW_2       = 8,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    product_bcd_display_if.slave    bus
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int SW = 7 * NUM_DIGITS;
    localparam int CW = $clog2(DW_2 + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;

    logic [BW-1:0]     scratch_r;
    logic [DW_2-1:0]   mag_r;
    logic [CW-1:0]     cnt_r;
    logic              sign_r;
    logic              nonzero_r;
    logic              ovf_int_r;

    logic              busy_r;
    logic              done_r;
    logic              ovf_r;
    logic [BW-1:0]     bcd_r;
    logic [SW-1:0]     seg_r;
    logic              seg_minus_r;

    logic [BW-1:0]     adj_s;
    logic              shift_out_s;
    logic [BW-1:0]     scratch_shift_s;
    logic [DW_2-1:0]   mag_shift_s;
    logic [SW-1:0]     seg_s;

    // 7-segment encoding of one BCD digit, gfedcba, active-high
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // One double-dabble step: add 3 to nibbles >= 5, then shift {scratch, mag} left
    always_comb begin
        adj_s = scratch_r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scratch_r[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = scratch_r[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = scratch_r[4*i +: 4];
            end
        end
        {shift_out_s, scratch_shift_s, mag_shift_s} = {adj_s, mag_r, 1'b0};
    end

    // Segment patterns for the finished scratch value, with optional zero blanking
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic zero_run_s;
        zero_run_s = 1'b1;
`endif
        seg_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seg_s[7*i +: 7] = seg7(scratch_r[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            // Digit 0 is always shown, so a zero result still displays "0"
            if (zero_run_s && (scratch_r[4*i +: 4] == 4'd0) && (i > 0)) begin
                seg_s[7*i +: 7] = 7'h00;
            end else begin
                zero_run_s = 1'b0;
            end
`endif
        end
    end

    // Next-state logic for IDLE -> SHIFT (DW_2 cycles) -> DONE -> IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CW'(1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Conversion datapath and registered outputs; start outside IDLE is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scratch_r   <= '0;
            mag_r       <= '0;
            cnt_r       <= '0;
            sign_r      <= 1'b0;
            nonzero_r   <= 1'b0;
            ovf_int_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ovf_r       <= 1'b0;
            bcd_r       <= '0;
            seg_r       <= '0;
            seg_minus_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sign_r    <= bus.sign;
                        nonzero_r <= (bus.product != '0);
                        mag_r     <= bus.product;
                        scratch_r <= '0;
                        cnt_r     <= CW'(DW_2);
                        ovf_int_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    done_r    <= 1'b0;
                    scratch_r <= scratch_shift_s;
                    mag_r     <= mag_shift_s;
                    cnt_r     <= cnt_r - CW'(1);
                    // A carry out of the top digit means the value needs more digits
                    ovf_int_r <= ovf_int_r | shift_out_s;
                end
                ST_DONE: begin
                    bcd_r       <= scratch_r;
                    seg_r       <= seg_s;
                    // Negative zero is shown without a minus sign
                    seg_minus_r <= sign_r & nonzero_r;
                    ovf_r       <= ovf_int_r;
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.ovf       = ovf_r;
    assign bus.bcd       = bcd_r;
    assign bus.seg       = seg_r;
    assign bus.seg_minus = seg_minus_r;

endmodule

// File: tb/tb_product_bcd_display.sv
// Testbench for product_bcd_display: a 3-digit and a 2-digit instance, random and
// directed operands, checked against a decimal-arithmetic reference model.
module tb_product_bcd_display;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    product_bcd_display_if #(.DW_2(8), .NUM_DIGITS(3)) ifa ();
    product_bcd_display_if #(.DW_2(8), .NUM_DIGITS(2)) ifb ();

    product_bcd_display #(.DW_2(8), .NUM_DIGITS(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    product_bcd_display #(.DW_2(8), .NUM_DIGITS(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    // Reference: plain decimal arithmetic on the captured operand
    task automatic ref_model(input int p, input bit s, input int nd,
                             output logic [31:0] e_bcd, output logic [31:0] e_seg,
                             output logic [31:0] e_ovf, output logic [31:0] e_minus);
        int pt;
        int d;
        logic [31:0] sg;
        e_ovf   = (p >= pow10(nd)) ? 32'd1 : 32'd0;
        e_minus = (s && p != 0) ? 32'd1 : 32'd0;
        pt      = p % pow10(nd);
        e_bcd   = 32'd0;
        e_seg   = 32'd0;
        for (int i = 0; i < nd; i++) begin
            d = (pt / pow10(i)) % 10;
            e_bcd = e_bcd | (32'(d) << (4 * i));
            sg = 32'(seg_tab[d]);
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && pt < pow10(i)) sg = 32'd0;
`endif
            e_seg = e_seg | (sg << (7 * i));
        end
    endtask

    task automatic set_req(input bit use_b, input logic st, input logic s, input logic [7:0] p);
        if (use_b) begin
            ifb.start = st; ifb.sign = s; ifb.product = p;
        end else begin
            ifa.start = st; ifa.sign = s; ifa.product = p;
        end
    endtask

    // Run one conversion; hold_start keeps start high (with junk operands) until done
    task automatic convert(input bit use_b, input logic s, input logic [7:0] p, input bit hold_start);
        int lat = 0;
        bit seen = 1'b0;
        int nd = use_b ? 2 : 3;
        logic [31:0] e_bcd, e_seg, e_ovf, e_minus;
        logic [31:0] o_bcd, o_seg, o_ovf, o_minus, o_busy, o_done;
        string nm = use_b ? "b" : "a";
        @(negedge clk);
        set_req(use_b, 1'b1, s, p);
        @(posedge clk);
        #1;
        set_req(use_b, hold_start, ~s, 8'($urandom_range(0, 255)));
        o_busy = use_b ? 32'(ifb.busy) : 32'(ifa.busy);
        check_val({nm, "_busy_after_start"}, o_busy, 32'd1);
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            o_done = use_b ? 32'(ifb.done) : 32'(ifa.done);
            if (o_done == 32'd1) begin
                seen = 1'b1;
                set_req(use_b, 1'b0, 1'b0, 8'd0);
            end else if (hold_start) begin
                set_req(use_b, 1'b1, ~s, 8'($urandom_range(0, 255)));
            end
        end
        check_val({nm, "_done_seen"}, 32'(seen), 32'd1);
        check_val({nm, "_latency"}, 32'(lat), 32'd9);
        ref_model(int'(p), s, nd, e_bcd, e_seg, e_ovf, e_minus);
        o_bcd   = use_b ? 32'(ifb.bcd) : 32'(ifa.bcd);
        o_seg   = use_b ? 32'(ifb.seg) : 32'(ifa.seg);
        o_ovf   = use_b ? 32'(ifb.ovf) : 32'(ifa.ovf);
        o_minus = use_b ? 32'(ifb.seg_minus) : 32'(ifa.seg_minus);
        check_val({nm, "_bcd"}, o_bcd, e_bcd);
        check_val({nm, "_seg"}, o_seg, e_seg);
        check_val({nm, "_ovf"}, o_ovf, e_ovf);
        check_val({nm, "_seg_minus"}, o_minus, e_minus);
        @(posedge clk);
        #1;
        o_done = use_b ? 32'(ifb.done) : 32'(ifa.done);
        o_busy = use_b ? 32'(ifb.busy) : 32'(ifa.busy);
        check_val({nm, "_done_one_cycle"}, o_done, 32'd0);
        check_val({nm, "_busy_after_done"}, o_busy, 32'd0);
        o_bcd = use_b ? 32'(ifb.bcd) : 32'(ifa.bcd);
        check_val({nm, "_bcd_held"}, o_bcd, e_bcd);
    endtask

    task automatic check_a_zero(input string tag);
        check_val({tag, "_busy"}, 32'(ifa.busy), 32'd0);
        check_val({tag, "_done"}, 32'(ifa.done), 32'd0);
        check_val({tag, "_ovf"}, 32'(ifa.ovf), 32'd0);
        check_val({tag, "_bcd"}, 32'(ifa.bcd), 32'd0);
        check_val({tag, "_seg"}, 32'(ifa.seg), 32'd0);
        check_val({tag, "_minus"}, 32'(ifa.seg_minus), 32'd0);
    endtask

    initial begin
        int dones;
        rst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 8'd0);
        set_req(1'b1, 1'b0, 1'b0, 8'd0);
        #23;
        check_a_zero("reset");
        check_val("reset_b_bcd", 32'(ifb.bcd), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases on the 3-digit instance
        convert(1'b0, 1'b1, 8'd49, 1'b0);
        convert(1'b0, 1'b0, 8'd255, 1'b0);
        convert(1'b0, 1'b1, 8'd0, 1'b0);
        convert(1'b0, 1'b0, 8'd100, 1'b0);
        convert(1'b0, 1'b1, 8'd49, 1'b1);

        // Overflow behaviour on the 2-digit instance
        convert(1'b1, 1'b0, 8'd123, 1'b0);
        convert(1'b1, 1'b0, 8'd7, 1'b0);
        convert(1'b1, 1'b1, 8'd99, 1'b0);
        convert(1'b1, 1'b1, 8'd100, 1'b0);

        // Randomized operands on both instances
        for (int n = 0; n < 20; n++) begin
            convert(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            convert(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
        end

        // Asynchronous reset in the middle of a conversion
        convert(1'b0, 1'b1, 8'd201, 1'b0);
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'd77);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 8'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_a_zero("midreset");
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (ifa.done) dones++;
        end
        check_val("midreset_no_done", 32'(dones), 32'd0);
        check_val("midreset_idle_busy", 32'(ifa.busy), 32'd0);
        convert(1'b0, 1'b0, 8'd58, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
